if_fetch_unit: RTL and testbench

Instruction-fetch initiator that drives the instruction ROM's enable/address pair and captures the returned word. It holds the program counter, sequences PC+4, applies branch redirects with MIPS delay-slot semantics, and honours pipeline stall/flush. It presents {pc, inst, valid} to the ID stage through a registered IF/ID boundary.

---
 rtl/cpu_defs_pkg.sv | 18 +
 rtl/if_id_reg.sv | 34 +++
 rtl/if_fetch_unit.sv | 71 +++++++
 tb/tb_if_fetch_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared constants and types for the CPU front-end: widths, reset PC, NOP word
// and the fetch FSM state type.
package cpu_defs_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned ROM_AW = 6;
  localparam int unsigned INST_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0000);
  localparam logic [PC_W-1:0]   RESET_PC = PC_W'(32'h0000_0000);
  localparam logic [PC_W-1:0]   PC_INC   = PC_W'(4);

  typedef enum logic {
    WAKE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline boundary register carrying {pc, inst, valid}; clear beats hold,
// hold beats load. A cleared slot carries a NOP and is marked not valid.
module if_id_reg
  import cpu_defs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              hold,
  input  logic [PC_W-1:0]   src_pc,
  input  logic [INST_W-1:0] src_inst,
  input  logic              src_valid,
  output logic [PC_W-1:0]   held_pc,
  output logic [INST_W-1:0] held_inst,
  output logic              held_valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_pc    <= '0;
      held_inst  <= NOP_INST;
      held_valid <= 1'b0;
    end else if (clr) begin
      held_pc    <= '0;
      held_inst  <= NOP_INST;
      held_valid <= 1'b0;
    end else if (!hold) begin
      held_pc    <= src_pc;
      held_inst  <= src_inst;
      held_valid <= src_valid;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC sequencing with delay-slot branches, stall/flush
// handling, ROM enable/address generation and the IF/ID boundary register.
module if_fetch_unit
  import cpu_defs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch_flag,
  input  logic [PC_W-1:0]   branch_target,
  output logic              rom_ce,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid
);

  fetch_state_t    state;
  logic [PC_W-1:0] target_aligned;
  logic            slot_clr;

  assign target_aligned = branch_target & ~PC_W'(3);
  assign rom_addr       = pc[ROM_AW+1:2];

  // The wake cycle and a flush both load a bubble into IF/ID.
  assign slot_clr = flush | (state == WAKE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= WAKE;
      pc     <= RESET_PC;
      rom_ce <= 1'b0;
    end else begin
      case (state)
        WAKE: begin
          state  <= RUN;
          rom_ce <= 1'b1;
        end
        RUN: begin
          // A branch alongside flush still redirects; under stall it must be re-presented.
          if (flush) begin
            if (branch_flag) pc <= target_aligned;
          end else if (!stall) begin
            pc <= branch_flag ? target_aligned : pc + PC_INC;
          end
        end
        default: begin
          state  <= WAKE;
          rom_ce <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk       (clk),
    .rst       (rst),
    .clr       (slot_clr),
    .hold      (stall),
    .src_pc    (pc),
    .src_inst  (rom_inst),
    .src_valid (1'b1),
    .held_pc   (id_pc),
    .held_inst (id_inst),
    .held_valid(id_valid)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, async-reset sequence, then
// randomized traffic checked against a cycle-level reference model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic        rom_ce;
  logic [5:0]  rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] pc;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  logic [31:0] rom [64];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rom_inst = rom_ce ? rom[rom_addr] : 32'h0;

  if_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .rom_ce       (rom_ce),
    .rom_addr     (rom_addr),
    .rom_inst     (rom_inst),
    .pc           (pc),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_valid     (id_valid)
  );

  typedef struct {
    logic        s, f, b;
    logic [31:0] tgt;
    logic [31:0] e_pc, e_id_pc, e_id_inst;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic s, input logic f, input logic b, input logic [31:0] t,
                         input logic [31:0] p, input logic [31:0] ip, input logic [31:0] ii,
                         input logic iv);
    vec_t v;
    v.s = s; v.f = f; v.b = b; v.tgt = t;
    v.e_pc = p; v.e_id_pc = ip; v.e_id_inst = ii; v.e_valid = iv;
    vecs.push_back(v);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_rom_ce"}, 32'(rom_ce), 32'h0);
    check({tag, "_id_valid"}, 32'(id_valid), 32'h0);
    check({tag, "_id_inst"}, id_inst, 32'h0);
    check({tag, "_id_pc"}, id_pc, 32'h0);
  endtask

  // Reference model: cycles since reset, then the fetch rules applied per edge.
  int          m_age;
  logic [31:0] m_pc, m_id_pc, m_id_inst;
  logic        m_valid, m_ce;

  task automatic model_reset();
    m_age = 0; m_pc = 32'h0; m_id_pc = 32'h0; m_id_inst = 32'h0; m_valid = 1'b0; m_ce = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic f, input logic b, input logic [31:0] t);
    logic [31:0] word;
    word = m_ce ? rom[(m_pc / 4) % 64] : 32'h0;
    if (m_age == 0) begin
      m_ce = 1'b1;
      m_id_pc = 0; m_id_inst = 0; m_valid = 1'b0;
    end else if (f) begin
      m_id_pc = 0; m_id_inst = 0; m_valid = 1'b0;
      if (b) m_pc = t - (t % 4);
    end else if (!s) begin
      m_id_pc = m_pc; m_id_inst = word; m_valid = 1'b1;
      m_pc = b ? t - (t % 4) : m_pc + 32'd4;
    end
    m_age++;
  endtask

  initial begin
    for (int k = 0; k < 64; k++) rom[k] = 32'h1000_0000 + 32'(k);

    // stall flush br target | pc id_pc id_inst valid
    add_vec(0,0,0,32'h0,  32'h0,        32'h0,        32'h0,        0); // wake
    add_vec(0,0,0,32'h0,  32'h4,        32'h0,        32'h1000_0000,1);
    add_vec(0,0,0,32'h0,  32'h8,        32'h4,        32'h1000_0001,1);
    add_vec(1,0,0,32'h0,  32'h8,        32'h4,        32'h1000_0001,1);
    add_vec(1,0,0,32'h0,  32'h8,        32'h4,        32'h1000_0001,1);
    add_vec(1,0,0,32'h0,  32'h8,        32'h4,        32'h1000_0001,1);
    add_vec(0,0,0,32'h0,  32'hC,        32'h8,        32'h1000_0002,1);
    add_vec(0,0,0,32'h0,  32'h10,       32'hC,        32'h1000_0003,1);
    add_vec(0,0,1,32'h22, 32'h20,       32'h10,       32'h1000_0004,1);
    add_vec(0,0,0,32'h0,  32'h24,       32'h20,       32'h1000_0008,1);
    add_vec(0,1,1,32'h40, 32'h40,       32'h0,        32'h0,        0);
    add_vec(0,0,0,32'h0,  32'h44,       32'h40,       32'h1000_0010,1);
    add_vec(1,1,0,32'h0,  32'h44,       32'h0,        32'h0,        0);
    add_vec(0,0,0,32'h0,  32'h48,       32'h44,       32'h1000_0011,1);
    add_vec(1,0,1,32'hFFFF_FFFC, 32'h48, 32'h44,      32'h1000_0011,1);
    add_vec(0,0,1,32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h48, 32'h1000_0012,1);
    add_vec(0,0,0,32'h0,  32'h0,        32'hFFFF_FFFC,32'h1000_003F,1);
    add_vec(0,0,1,32'hF8, 32'hF8,       32'h0,        32'h1000_0000,1);
    add_vec(0,0,0,32'h0,  32'hFC,       32'hF8,       32'h1000_003E,1);
    add_vec(0,0,0,32'h0,  32'h100,      32'hFC,       32'h1000_003F,1);
    add_vec(0,0,0,32'h0,  32'h104,      32'h100,      32'h1000_0000,1);

    #3;
    check_reset_vals("rst_hold");
    @(posedge clk); #1;
    rst = 1'b1;
    check_reset_vals("rst_release");

    for (int i = 0; i < vecs.size(); i++) begin
      stall = vecs[i].s; flush = vecs[i].f;
      branch_flag = vecs[i].b; branch_target = vecs[i].tgt;
      cyc();
      check($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      check($sformatf("v%0d_rom_addr", i), 32'(rom_addr), 32'((vecs[i].e_pc >> 2) & 32'h3F));
      check($sformatf("v%0d_rom_ce", i), 32'(rom_ce), 32'h1);
      check($sformatf("v%0d_id_pc", i), id_pc, vecs[i].e_id_pc);
      check($sformatf("v%0d_id_inst", i), id_inst, vecs[i].e_id_inst);
      check($sformatf("v%0d_id_valid", i), 32'(id_valid), 32'(vecs[i].e_valid));
    end

    // Async reset in the middle of a stalled cycle, then wake with stall still high.
    stall = 1'b0; flush = 1'b0; branch_flag = 1'b0;
    cyc(); cyc();
    stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h80;
    cyc();
    check("stall_pc", pc, 32'h10C);
    #2 rst = 1'b0;
    #1;
    check_reset_vals("async_rst");
    cyc();
    check_reset_vals("async_rst_held");
    rst = 1'b1; branch_flag = 1'b0;
    cyc();
    check("wake_rom_ce", 32'(rom_ce), 32'h1);
    check("wake_pc", pc, 32'h0);
    check("wake_id_valid", 32'(id_valid), 32'h0);
    stall = 1'b0;
    cyc();
    check("restart_id_inst", id_inst, 32'h1000_0000);
    check("restart_id_valid", 32'(id_valid), 32'h1);
    check("restart_pc", pc, 32'h4);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 64; k++) rom[k] = $urandom;
    rst = 1'b0; stall = 1'b0; flush = 1'b0; branch_flag = 1'b0;
    #1;
    model_reset();
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b0;
        #1;
        model_reset();
        check("rnd_async_pc", pc, m_pc);
        check("rnd_async_valid", 32'(id_valid), 32'(m_valid));
        check("rnd_async_ce", 32'(rom_ce), 32'(m_ce));
        @(posedge clk); #1;
        rst = 1'b1;
      end else begin
        stall = ($urandom_range(0, 3) == 0);
        flush = ($urandom_range(0, 9) == 0);
        branch_flag = ($urandom_range(0, 4) == 0);
        branch_target = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 511));
        cyc();
        model_step(stall, flush, branch_flag, branch_target);
        check("rnd_pc", pc, m_pc);
        check("rnd_rom_addr", 32'(rom_addr), (m_pc / 4) % 64);
        check("rnd_rom_ce", 32'(rom_ce), 32'(m_ce));
        check("rnd_id_pc", id_pc, m_id_pc);
        check("rnd_id_inst", id_inst, m_id_inst);
        check("rnd_id_valid", 32'(id_valid), 32'(m_valid));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
